xs_maincpu_io_responder: RTL

Bus-side responder for the main MC6809E (synchronous core on `clk_49m` with E/Q fall enables). Decodes the CPU's I/O page, returns input and DIP-switch data on reads, and commits writes to the sound latch, bank/flip register and interrupt-acknowledge strobes. It also owns the CPU's `nIRQ`/`nFIRQ`/`nNMI` request flip-flops. Sits between the CPU instance and the rest of the main board, so the CPU wrapper only needs an external-data passthrough.

---
 rtl/xs_pkg.sv | 23 ++
 rtl/xs_irq_flag.sv | 31 +++
 rtl/xs_maincpu_io_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/xs_pkg.sv
// Shared constants and types for the main-CPU I/O page responder.
package xs_pkg;

  localparam logic [15:0] IO_BASE = 16'h3A00;

  localparam logic [3:0] IO_P1       = 4'h0;
  localparam logic [3:0] IO_P2       = 4'h1;
  localparam logic [3:0] IO_SYS      = 4'h2;
  localparam logic [3:0] IO_DSW1     = 4'h3;
  localparam logic [3:0] IO_DSW2     = 4'h4;
  localparam logic [3:0] IO_SNDLATCH = 4'h8;
  localparam logic [3:0] IO_NMIACK   = 4'h9;
  localparam logic [3:0] IO_FIRQACK  = 4'hA;
  localparam logic [3:0] IO_IRQACK   = 4'hB;
  localparam logic [3:0] IO_BANKFLIP = 4'hC;

  typedef struct packed {
    logic nmi;
    logic firq;
    logic irq;
  } irq_flags_t;

endpackage

// File: rtl/xs_irq_flag.sv
// Set/clear request flip-flop; a set in the same clock as a clear wins.
module xs_irq_flag (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic set_i,
  input  logic clr_i,
  output logic flag_o
);

  logic flag_q, flag_d;

  always_comb begin
    flag_d = flag_q;
    if (set_i) begin
      flag_d = 1'b1;
    end else if (clr_i) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/xs_maincpu_io_responder.sv
// Main MC6809E I/O page: input/DIP reads, sound latch, bank/flip and
// interrupt request flags with acknowledge strobes.
module xs_maincpu_io_responder
  import xs_pkg::*;
(
  input  logic        clk_49m,
  input  logic        RSTn,
  input  logic        cpu_E_en,
  input  logic        cpu_Q_en,
  input  logic [15:0] cpu_A,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_Dout,
  input  logic [7:0]  ext_Din,
  output logic [7:0]  cpu_Din,
  output logic        io_sel,
  input  logic [7:0]  P1,
  input  logic [7:0]  P2,
  input  logic [7:0]  SYS,
  input  logic [7:0]  DSW1,
  input  logic [7:0]  DSW2,
  input  logic        vblank,
  input  logic        firq_req,
  input  logic        irq_req,
  output logic        cpu_nNMI,
  output logic        cpu_nFIRQ,
  output logic        cpu_nIRQ,
  output logic [7:0]  snd_latch,
  output logic        snd_wr,
  output logic [2:0]  bank,
  output logic        flip
);

  logic [3:0] offset;
  logic [7:0] rd_data;
  logic       wr_en;
  logic [7:0] din_q;
  logic [7:0] snd_latch_q;
  logic       snd_wr_q;
  logic [2:0] bank_q;
  logic       flip_q;
  logic       vblank_q;
  irq_flags_t set, ack, flags;

  // SYS[0] is replaced by vblank on reads.
  logic unused_sys;
  assign unused_sys = SYS[0];

  assign io_sel = (cpu_A[15:4] == IO_BASE[15:4]);
  assign offset = cpu_A[3:0];
  assign wr_en  = cpu_E_en & ~cpu_rw & io_sel;

  always_comb begin
    rd_data = ext_Din;
    if (io_sel) begin
      unique case (offset)
        IO_P1:   rd_data = P1;
        IO_P2:   rd_data = P2;
        IO_SYS:  rd_data = {SYS[7:1], vblank};
        IO_DSW1: rd_data = DSW1;
        IO_DSW2: rd_data = DSW2;
        default: rd_data = 8'hFF;
      endcase
    end
  end

  always_comb begin
    set.nmi  = vblank & ~vblank_q;
    set.firq = firq_req;
    set.irq  = irq_req;
    ack.nmi  = wr_en & (offset == IO_NMIACK);
    ack.firq = wr_en & (offset == IO_FIRQACK);
    ack.irq  = wr_en & (offset == IO_IRQACK);
  end

  always_ff @(posedge clk_49m or negedge RSTn) begin
    if (!RSTn) begin
      din_q       <= 8'hFF;
      snd_latch_q <= 8'h00;
      snd_wr_q    <= 1'b0;
      bank_q      <= 3'd0;
      flip_q      <= 1'b0;
      vblank_q    <= 1'b0;
    end else begin
      vblank_q <= vblank;
      snd_wr_q <= wr_en & (offset == IO_SNDLATCH);
      if (cpu_Q_en) begin
        din_q <= rd_data;
      end
      if (wr_en && offset == IO_SNDLATCH) begin
        snd_latch_q <= cpu_Dout;
      end
      if (wr_en && offset == IO_BANKFLIP) begin
        bank_q <= cpu_Dout[2:0];
        flip_q <= cpu_Dout[7];
      end
    end
  end

  xs_irq_flag u_nmi_flag (
    .clk_i  (clk_49m),
    .rst_ni (RSTn),
    .set_i  (set.nmi),
    .clr_i  (ack.nmi),
    .flag_o (flags.nmi)
  );

  xs_irq_flag u_firq_flag (
    .clk_i  (clk_49m),
    .rst_ni (RSTn),
    .set_i  (set.firq),
    .clr_i  (ack.firq),
    .flag_o (flags.firq)
  );

  xs_irq_flag u_irq_flag (
    .clk_i  (clk_49m),
    .rst_ni (RSTn),
    .set_i  (set.irq),
    .clr_i  (ack.irq),
    .flag_o (flags.irq)
  );

  assign cpu_Din   = din_q;
  assign snd_latch = snd_latch_q;
  assign snd_wr    = snd_wr_q;
  assign bank      = bank_q;
  assign flip      = flip_q;
  assign cpu_nNMI  = ~flags.nmi;
  assign cpu_nFIRQ = ~flags.firq;
  assign cpu_nIRQ  = ~flags.irq;

endmodule
